// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter with a held, registered one-hot grant and a hold timer
// that preempts an owner exceeding MAX_HOLD cycles while others are waiting.
module rr_lock_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16,
  localparam int IDW     = (N > 1) ? $clog2(N) : 1,
  localparam int HW      = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id,
  output logic           preempt
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  state_t         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic           valid_q, valid_d;
  logic [IDW-1:0] id_q, id_d;
  logic           pre_q, pre_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [HW-1:0]  hold_q, hold_d;

  logic [N-1:0]   others_s;
  logic [IDW-1:0] nxt_s;
  logic [IDW-1:0] pick_ptr_s;
  logic [IDW-1:0] pick_nxt_s;

  // First set request bit at or after start, wrapping cyclically.
  function automatic logic [IDW-1:0] rr_pick(input logic [N-1:0] r, input logic [IDW-1:0] start);
    logic [IDW-1:0] idx;
    logic           found;
    rr_pick = start;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = IDW'((int'(start) + k) % N);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] idx);
    if (int'(idx) == N - 1) begin
      next_idx = {IDW{1'b0}};
    end else begin
      next_idx = idx + IDW'(1);
    end
  endfunction

  function automatic logic [N-1:0] to_onehot(input logic [IDW-1:0] idx);
    to_onehot      = {N{1'b0}};
    to_onehot[idx] = 1'b1;
  endfunction

  assign others_s   = req & ~gnt_q;
  assign nxt_s      = next_idx(id_q);
  assign pick_ptr_s = rr_pick(req, ptr_q);
  assign pick_nxt_s = rr_pick(req, nxt_s);

  // Next-state decision: release beats timeout, timeout beats hold.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    id_d    = id_q;
    pre_d   = 1'b0;
    ptr_d   = ptr_q;
    hold_d  = hold_q;

    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_OWN;
          id_d    = pick_ptr_s;
          gnt_d   = to_onehot(pick_ptr_s);
          valid_d = 1'b1;
          hold_d  = {HW{1'b0}};
        end else begin
          gnt_d   = {N{1'b0}};
          valid_d = 1'b0;
          id_d    = {IDW{1'b0}};
        end
      end
      ST_OWN: begin
        if (!req[id_q]) begin
          ptr_d  = nxt_s;
          hold_d = {HW{1'b0}};
          if (|others_s) begin
            id_d    = pick_nxt_s;
            gnt_d   = to_onehot(pick_nxt_s);
            valid_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
            id_d    = {IDW{1'b0}};
            gnt_d   = {N{1'b0}};
            valid_d = 1'b0;
          end
        end else if ((hold_q == HOLD_LAST) && (|others_s)) begin
          // Owner still requesting, so the cyclic search from i+1 lands on a waiter.
          ptr_d   = nxt_s;
          id_d    = pick_nxt_s;
          gnt_d   = to_onehot(pick_nxt_s);
          valid_d = 1'b1;
          pre_d   = 1'b1;
          hold_d  = {HW{1'b0}};
        end else begin
          if (hold_q != HOLD_LAST) begin
            hold_d = hold_q + HW'(1);
          end else begin
            hold_d = hold_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = {N{1'b0}};
        valid_d = 1'b0;
        id_d    = {IDW{1'b0}};
        ptr_d   = {IDW{1'b0}};
        hold_d  = {HW{1'b0}};
      end
    endcase
  end

  // State and output registers; reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= {N{1'b0}};
      valid_q <= 1'b0;
      id_q    <= {IDW{1'b0}};
      pre_q   <= 1'b0;
      ptr_q   <= {IDW{1'b0}};
      hold_q  <= {HW{1'b0}};
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      pre_q   <= pre_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = valid_q;
  assign gnt_id    = id_q;
  assign preempt   = pre_q;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Scoreboard bench for rr_lock_arbiter (N = 4, MAX_HOLD = 4): a cycle model
// queues expected outputs as stimulus is driven; they are compared after the edge.
module tb_rr_lock_arbiter;
  localparam int N  = 4;
  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic       preempt;

  typedef struct packed {
    logic [3:0] gnt;
    logic       valid;
    logic [1:0] id;
    logic       pre;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state
  bit m_own  = 0;
  int m_id   = 0;
  int m_ptr  = 0;
  int m_hold = 0;
  bit m_pre  = 0;

  rr_lock_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .preempt   (preempt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      if (r[(start + k) % N]) return (start + k) % N;
    end
    return start;
  endfunction

  task automatic model_step(input logic r_rst, input logic [3:0] r);
    logic [3:0] others;
    m_pre = 0;
    if (r_rst) begin
      m_own = 0; m_id = 0; m_ptr = 0; m_hold = 0;
    end else if (!m_own) begin
      if (r != 4'b0000) begin
        m_own = 1; m_id = pick(r, m_ptr); m_hold = 0;
      end
    end else begin
      others = r;
      others[m_id] = 1'b0;
      if (!r[m_id]) begin
        m_ptr = (m_id + 1) % N;
        m_hold = 0;
        if (others != 4'b0000) m_id = pick(r, m_ptr);
        else begin m_own = 0; m_id = 0; end
      end else if (m_hold == MH - 1 && others != 4'b0000) begin
        m_ptr = (m_id + 1) % N;
        m_id = pick(r, m_ptr);
        m_pre = 1;
        m_hold = 0;
      end else if (m_hold < MH - 1) begin
        m_hold = m_hold + 1;
      end
    end
  endtask

  // One clock: drive at negedge, queue expectation, compare 1 time unit after posedge.
  task automatic step(input logic r_rst, input logic [3:0] r);
    exp_t e;
    @(negedge clk);
    rst = r_rst;
    req = r;
    model_step(r_rst, r);
    e.gnt   = m_own ? (4'b0001 << m_id) : 4'b0000;
    e.valid = m_own;
    e.id    = m_own ? m_id[1:0] : 2'd0;
    e.pre   = m_pre;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq("queue_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq("gnt", gnt, e.gnt);
      check_eq("gnt_valid", gnt_valid, e.valid);
      check_eq("gnt_id", gnt_id, e.id);
      check_eq("preempt", preempt, e.pre);
    end
    check_eq("onehot", $onehot0(gnt), 1);
  endtask

  initial begin
    logic [3:0] r;
    logic [3:0] last;
    logic [3:0] seq[$];
    int         gaps;
    int         pres;

    // 1. Reset dominates requests, first grant follows
    step(1'b1, 4'b1111);
    check_eq("rst_gnt", gnt, 4'b0000);
    check_eq("rst_valid", gnt_valid, 1'b0);
    step(1'b0, 4'b1111);
    check_eq("first_gnt", gnt, 4'b0001);

    // 2. Rotation: owner drops req two cycles into its grant
    step(1'b1, 4'b0000);
    last = 4'b0000; gaps = 0; pres = 0;
    for (int c = 0; c < 12; c++) begin
      r = 4'b1111;
      if (m_own && m_hold == 1) r[m_id] = 1'b0;
      step(1'b0, r);
      if (gnt == 4'b0000) gaps++;
      if (preempt) pres++;
      if (gnt != last && gnt != 4'b0000) seq.push_back(gnt);
      last = gnt;
    end
    check_eq("rot_len", (seq.size() >= 5), 1);
    if (seq.size() >= 5) begin
      check_eq("rot0", seq[0], 4'b0001);
      check_eq("rot1", seq[1], 4'b0010);
      check_eq("rot2", seq[2], 4'b0100);
      check_eq("rot3", seq[3], 4'b1000);
      check_eq("rot4", seq[4], 4'b0001);
    end
    check_eq("rot_gaps", gaps, 0);
    check_eq("rot_preempt", pres, 0);

    // 3. Timeout alternation with req = 0011
    step(1'b1, 4'b0000);
    for (int k = 1; k <= 16; k++) begin
      step(1'b0, 4'b0011);
      check_eq("to_gnt", gnt, (((k - 1) / 4) % 2) ? 4'b0010 : 4'b0001);
      check_eq("to_pre", preempt, (k > 1 && (k - 1) % 4 == 0));
    end

    // 4. Lone owner never preempted
    step(1'b1, 4'b0000);
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 4'b0100);
      check_eq("lone_gnt", gnt, 4'b0100);
      check_eq("lone_id", gnt_id, 2'd2);
      check_eq("lone_pre", preempt, 1'b0);
    end

    // 5. Release to empty, then reset while 1000 is granted
    step(1'b1, 4'b0000);
    step(1'b0, 4'b0010);
    step(1'b0, 4'b0010);
    step(1'b0, 4'b0000);
    check_eq("rel_gnt", gnt, 4'b0000);
    check_eq("rel_valid", gnt_valid, 1'b0);
    step(1'b0, 4'b1000);
    check_eq("own3", gnt, 4'b1000);
    step(1'b1, 4'b1000);
    check_eq("midrst_gnt", gnt, 4'b0000);
    step(1'b0, 4'b1111);
    check_eq("midrst_ptr0", gnt, 4'b0001);

    // 6. Release in the timeout cycle is a plain handover
    step(1'b1, 4'b0000);
    for (int k = 0; k < 4; k++) step(1'b0, 4'b0011);
    check_eq("tie_pre_hold", m_hold, MH - 1);
    step(1'b0, 4'b0010);
    check_eq("tie_gnt", gnt, 4'b0010);
    check_eq("tie_pre", preempt, 1'b0);

    // Random traffic with occasional reset
    for (int k = 0; k < 300; k++) begin
      step(($urandom_range(0, 40) == 0), 4'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
